// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle, followed by a single sign-fix cycle that writes the Hi/Lo results.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MTHI,
    input  logic             MTLO,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // {remainder/product-high, quotient/multiplier}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   m_q, m_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand magnitudes; Op[0] selects the unsigned variants.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign a_neg = ~Op[0] & A[WIDTH-1];
    assign b_neg = ~Op[0] & B[WIDTH-1];
    assign a_abs = a_neg ? -A : A;
    assign b_abs = b_neg ? -B : B;

    // One iteration of each algorithm.
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next;
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};
    // A borrow means the divisor did not fit: restore the shifted remainder.
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    // Sign-corrected results. A zero divisor leaves remainder = |A|, which the
    // remainder sign fix turns back into A; only the quotient is overridden.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
    assign prod   = neg_q ? -acc_q : acc_q;
    assign quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign res_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    assign res_lo = div_q ? (bzero_q ? '1 : quo) : prod[WIDTH-1:0];

    // Next-state, datapath and result-register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    acc_d     = {{WIDTH{1'b0}}, a_abs};
                    m_d       = b_abs;
                    div_d     = Op[1];
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = Op[1] & a_neg;
                    bzero_d   = Op[1] & (B == '0);
                    cnt_d     = '0;
                    state_d   = RUN;
                end else begin
                    if (MTHI) hi_d = WriteData;
                    if (MTLO) lo_d = WriteData;
                end
            end
            RUN: begin
                acc_d = div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: stimulus pushes expected {Hi,Lo},
// a negedge monitor pops and compares on every Done pulse.
module tb_mult_div_sequencer;

    logic        Clk = 1'b0;
    logic        Rst, Start, MTHI, MTLO, Busy, Done;
    logic [1:0]  Op;
    logic [31:0] A, B, WriteData, Hi, Lo;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cur_hi, cur_lo;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .MTHI(MTHI), .MTLO(MTLO), .WriteData(WriteData),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every Done pulse must match the oldest pending expectation.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("result_hi", Hi, e[63:32]);
                chk("result_lo", Lo, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input bit disturb, input bit mt_with_start);
        int cyc, busy_cnt;
        cyc = 0;
        while (Busy && cyc < 100) begin step(); cyc++; end
        if (Busy) chk("idle_timeout", 32'd1, 32'd0);
        exp_q.push_back({ehi, elo});
        Start = 1'b1; Op = op; A = a; B = b;
        if (mt_with_start) begin MTLO = 1'b1; WriteData = 32'h1111_1111; end
        step();
        Start = 1'b0; MTLO = 1'b0;
        A = $urandom; B = $urandom; Op = 2'($urandom);
        if (mt_with_start) chk("start_drops_mtlo", Lo, cur_lo);
        cyc = 0; busy_cnt = 0;
        while (!Done && cyc < 100) begin
            if (Busy) busy_cnt++;
            if (cyc == 10) begin
                chk("hold_hi_run", Hi, cur_hi);
                chk("hold_lo_run", Lo, cur_lo);
            end
            if (disturb && cyc == 5) begin
                Start = 1'b1; MTHI = 1'b1; MTLO = 1'b1; WriteData = 32'hDEAD_BEEF;
            end else begin
                Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
            end
            step();
            cyc++;
        end
        Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        chk("done_latency", 32'(cyc), 32'd33);
        chk("busy_cycles", 32'(busy_cnt), 32'd33);
        chk("busy_low_at_done", {31'd0, Busy}, 32'd0);
        cur_hi = ehi; cur_lo = elo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        MTHI = 1'b0; MTLO = 1'b0; WriteData = '0;
        step(); step();
        Rst = 1'b0;
        chk("reset_hi", Hi, 32'h0);
        chk("reset_lo", Lo, 32'h0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_done", {31'd0, Done}, 32'd0);
        cur_hi = 32'h0; cur_lo = 32'h0;

        // Direct Hi/Lo writes in IDLE
        MTHI = 1'b1; MTLO = 1'b1; WriteData = 32'hA5A5_A5A5;
        step();
        MTHI = 1'b0; MTLO = 1'b0;
        chk("mthi", Hi, 32'hA5A5_A5A5);
        chk("mtlo", Lo, 32'hA5A5_A5A5);
        cur_hi = 32'hA5A5_A5A5; cur_lo = 32'hA5A5_A5A5;

        // Arithmetic cases, issued back to back in each Done cycle
        run_op(MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        run_op(MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0);
        run_op(DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0);
        run_op(DIVU,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);

        // Reset in the middle of RUN aborts without a result
        Start = 1'b1; Op = MULT; A = 32'd5; B = 32'd5;
        step();
        Start = 1'b0;
        repeat (10) step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", Hi, 32'h0);
        chk("abort_lo", Lo, 32'h0);
        chk("abort_done", {31'd0, Done}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin step(); if (Done) saw_done = 1'b1; end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        cur_hi = 32'h0; cur_lo = 32'h0;

        run_op(MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1'b0);
        run_op(DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_sequencer.md
MULT_DIV_SEQUENCER -- requirements
Module: mult_div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width and the number of iteration cycles.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port Start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port Op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports A and B, inputs, WIDTH bits each: multiplicand/dividend (A) and multiplier/divisor (B); sampled with Start.
REQ-007 SHALL have ports MTHI and MTLO, inputs, 1 bit each: direct writes of WriteData to Hi and Lo.
REQ-008 SHALL have port WriteData, input, WIDTH bits: data source for MTHI/MTLO.
REQ-009 SHALL have ports Hi and Lo, outputs, WIDTH bits each: registered result registers.
REQ-010 SHALL have port Busy, output, 1 bit: an operation is in progress and the pipeline must stall.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle pulse marking that Hi/Lo now hold a new result.

Function
REQ-012 SHALL implement exactly three states:
- IDLE: waiting for Start.
- RUN: one iteration bit per cycle.
- FIX: sign correction and result write.
REQ-013 In IDLE with Start=1 at an edge, SHALL do all of the following:
- latch |A| and |B| (absolute values for signed Op; raw values for unsigned Op);
- latch the result signs;
- clear the iteration counter;
- enter RUN.
REQ-014 SHALL remain in RUN for exactly WIDTH cycles, performing one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle.
REQ-015 SHALL spend exactly one cycle in FIX, then return to IDLE, writing Hi/Lo at the edge that leaves FIX.
REQ-016 SHALL drive Busy=1 exactly in RUN and FIX (WIDTH+1 cycles) and Busy=0 otherwise; Busy SHALL be a registered output.
REQ-017 SHALL pulse Done=1 for exactly the one cycle following the FIX exit edge, so Done is visible WIDTH+1 cycles after the edge that sampled Start.
REQ-018 For MULT/MULTU, SHALL produce {Hi,Lo} equal to the 2*WIDTH-bit product:
- MULT: signed, negated in FIX when sign(A) XOR sign(B);
- MULTU: unsigned.
REQ-019 For DIV/DIVU, SHALL produce Lo = quotient and Hi = remainder:
- DIV: quotient truncated toward zero, quotient negated when sign(A) XOR sign(B);
- DIV: remainder takes the sign of A.
REQ-020 When B=0 in DIV/DIVU, SHALL produce Lo = all ones and Hi = A, with unchanged latency.
REQ-021 For DIV with A = most-negative and B = -1, SHALL produce Lo = A and Hi = 0, with unchanged latency.
REQ-022 SHALL ignore Start while Busy=1; no restart and no corruption of the operation in progress.
REQ-023 SHALL accept Start in the Done cycle (back-to-back operations, no idle gap required).
REQ-024 In IDLE without Start, MTHI SHALL load Hi and MTLO SHALL load Lo from WriteData at the edge; both may be asserted together.
REQ-025 SHALL give Start priority over MTHI/MTLO in the same IDLE cycle (MT writes dropped), and SHALL ignore MTHI/MTLO while Busy=1.
REQ-026 SHALL hold Hi/Lo stable during RUN and FIX; the previous result SHALL remain readable until the FIX exit edge.
REQ-027 A, B and Op SHALL be don't-care after the Start sampling edge.

Reset
REQ-028 With Rst=1 at an edge, SHALL force all of the following, regardless of state, including mid-RUN or FIX:
- state = IDLE;
- Hi = 0 and Lo = 0;
- Busy = 0 and Done = 0;
- iteration counter = 0.
REQ-029 Rst SHALL take priority over Start, MTHI and MTLO; an aborted operation SHALL write no result.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- MULT, A=0xFFFFFFFE (-2), B=0x00000003 -> Busy high 33 cycles; Done after 33 cycles; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV, A=-7 (0xFFFFFFF9), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU, A=100, B=7 -> Lo=14, Hi=2.
- DIVU, B=0, A=0x12345678 -> Lo=0xFFFFFFFF, Hi=0x12345678; DIV, A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI+MTLO with WriteData=0xA5A5A5A5 in IDLE -> Hi=Lo=0xA5A5A5A5 next cycle; Start plus MTLO in one cycle -> MTLO dropped; Start and MTHI pulses mid-RUN -> ignored, result unchanged.
- Rst asserted at RUN cycle 10 -> next cycle Busy=0, Hi=Lo=0, no Done; new Start then completes normally; back-to-back Start in a Done cycle -> second Done exactly 33 cycles later.
